// File: rtl/shift_seq_counter.sv
// Shift-register sequence counter (ring or Johnson), configurable width and direction.
// Latency: q/wrap/err update 1 edge after en/load/clr_err; qbar/idx/illegal are combinational from q.
// No backpressure: en advances one step per edge, load overrides en, an illegal code recovers to the reset value.
module shift_seq_counter #(
  parameter int WIDTH = 4,
  parameter int MODE  = 1,
  localparam int N    = (MODE != 0) ? 2 * WIDTH : WIDTH,
  localparam int IDXW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [IDXW-1:0]  idx,
  output logic             wrap,
  output logic             illegal,
  output logic             err
);

  // One spare bit so popcount/transition counts never overflow.
  localparam int CW = IDXW + 1;

  // Ring resets to a single one in the MSB; Johnson resets to all zeros.
  localparam logic [WIDTH-1:0] RST_VAL = (MODE == 0) ? {1'b1, {(WIDTH-1){1'b0}}}
                                                     : {WIDTH{1'b0}};
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(N - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_err;

  logic [CW-1:0]    w_pop;
  logic [CW-1:0]    w_trans;
  logic [IDXW-1:0]  w_ring_idx;
  logic [IDXW-1:0]  w_john_idx;
  logic [IDXW-1:0]  w_idx;
  logic             w_illegal;
  logic             w_fb_fwd;
  logic             w_fb_rev;
  logic [WIDTH-1:0] w_fwd;
  logic [WIDTH-1:0] w_rev;
  logic             w_recover;

  // Count set bits and adjacent-bit transitions; a Johnson code has at most one transition.
  always_comb begin
    w_pop   = '0;
    w_trans = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + CW'(r_q[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      w_trans = w_trans + CW'(r_q[i+1] ^ r_q[i]);
    end
  end

  // Ring index: position of the set bit counted from the MSB.
  always_comb begin
    w_ring_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_q[i]) begin
        w_ring_idx = IDXW'(WIDTH - 1 - i);
      end
    end
  end

  // Johnson index: filling phase (MSB set) counts ones, draining phase counts down from 2W.
  always_comb begin
    if (r_q == '0) begin
      w_john_idx = '0;
    end else if (r_q[WIDTH-1]) begin
      w_john_idx = w_pop[IDXW-1:0];
    end else begin
      w_john_idx = IDXW'(2 * WIDTH) - w_pop[IDXW-1:0];
    end
  end

  // Legality, decoded index and next-state candidates for both directions.
  always_comb begin
    w_illegal = (MODE != 0) ? (w_trans > CW'(1)) : (w_pop != CW'(1));
    if (w_illegal) begin
      w_idx = '0;
    end else if (MODE != 0) begin
      w_idx = w_john_idx;
    end else begin
      w_idx = w_ring_idx;
    end
    w_fb_fwd  = (MODE != 0) ? ~r_q[0] : r_q[0];
    w_fb_rev  = (MODE != 0) ? ~r_q[WIDTH-1] : r_q[WIDTH-1];
    w_fwd     = {w_fb_fwd, r_q[WIDTH-1:1]};
    w_rev     = {r_q[WIDTH-2:0], w_fb_rev};
    w_recover = !load && en && w_illegal;
  end

  // State register: load > recovery > step > hold; wrap flags the step that crosses the N-1/0 boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= RST_VAL;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (load) begin
        r_q <= load_val;
      end else if (en && w_illegal) begin
        r_q <= RST_VAL;
      end else if (en) begin
        r_q    <= dir ? w_rev : w_fwd;
        r_wrap <= dir ? (w_idx == '0) : (w_idx == IDX_LAST);
      end
      // A recovery on the same edge as clr_err leaves err set.
      if (w_recover) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign q       = r_q;
  assign qbar    = ~r_q;
  assign idx     = w_idx;
  assign wrap    = r_wrap;
  assign illegal = w_illegal;
  assign err     = r_err;

endmodule

// File: tb/tb_shift_seq_counter.sv
// Directed bench for shift_seq_counter: one Johnson and one ring instance, WIDTH = 4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Every expected value below is hand-computed from the sequence tables.
module tb_shift_seq_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  // Johnson instance signals
  logic       j_en, j_dir, j_load, j_clr;
  logic [3:0] j_lv;
  logic [3:0] j_q, j_qbar;
  logic [2:0] j_idx;
  logic       j_wrap, j_ill, j_err;

  // Ring instance signals
  logic       r_en, r_dir, r_load, r_clr;
  logic [3:0] r_lv;
  logic [3:0] r_q, r_qbar;
  logic [1:0] r_idx;
  logic       r_wrap, r_ill, r_err;

  shift_seq_counter #(.WIDTH(4), .MODE(1)) u_john (
    .clk(clk), .rst(rst), .en(j_en), .dir(j_dir), .load(j_load), .load_val(j_lv),
    .clr_err(j_clr), .q(j_q), .qbar(j_qbar), .idx(j_idx), .wrap(j_wrap),
    .illegal(j_ill), .err(j_err)
  );

  shift_seq_counter #(.WIDTH(4), .MODE(0)) u_ring (
    .clk(clk), .rst(rst), .en(r_en), .dir(r_dir), .load(r_load), .load_val(r_lv),
    .clr_err(r_clr), .q(r_q), .qbar(r_qbar), .idx(r_idx), .wrap(r_wrap),
    .illegal(r_ill), .err(r_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_j(input string tag, input logic [3:0] eq, input int eidx, input logic ew);
    check({tag, " j.q"},    32'(j_q),    32'(eq));
    check({tag, " j.idx"},  32'(j_idx),  32'(eidx));
    check({tag, " j.wrap"}, 32'(j_wrap), 32'(ew));
  endtask

  task automatic chk_r(input string tag, input logic [3:0] eq, input int eidx, input logic ew);
    check({tag, " r.q"},    32'(r_q),    32'(eq));
    check({tag, " r.idx"},  32'(r_idx),  32'(eidx));
    check({tag, " r.wrap"}, 32'(r_wrap), 32'(ew));
  endtask

  logic [3:0] jseq_q   [9] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111,
                               4'b0011, 4'b0001, 4'b0000, 4'b1000};
  int         jseq_idx [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
  logic       jseq_w   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    j_en = 0; j_dir = 0; j_load = 0; j_clr = 0; j_lv = '0;
    r_en = 0; r_dir = 0; r_load = 0; r_clr = 0; r_lv = '0;

    // Reset state of both instances
    #12;
    chk_j("reset", 4'b0000, 0, 1'b0);
    check("reset j.qbar", 32'(j_qbar), 32'hf);
    check("reset j.err",  32'(j_err),  32'h0);
    check("reset j.ill",  32'(j_ill),  32'h0);
    chk_r("reset", 4'b1000, 0, 1'b0);
    check("reset r.err",  32'(r_err),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Johnson forward through a full period plus one
    j_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_j($sformatf("jfwd%0d", k), jseq_q[k], jseq_idx[k], jseq_w[k]);
    end
    tick();
    chk_j("jto1100", 4'b1100, 2, 1'b0);

    // Hold at 1100 for 5 edges
    j_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_j($sformatf("jhold%0d", k), 4'b1100, 2, 1'b0);
    end
    chk_r("ring idle", 4'b1000, 0, 1'b0);

    // Load an illegal code, hold it, then recover
    j_lv = 4'b0110; j_load = 1'b1;
    tick();
    j_load = 1'b0;
    chk_j("jload0110", 4'b0110, 0, 1'b0);
    check("jload0110 ill", 32'(j_ill), 32'h1);
    tick();
    check("jillhold q",   32'(j_q),   32'h6);
    check("jillhold ill", 32'(j_ill), 32'h1);
    j_en = 1'b1;
    tick();
    j_en = 1'b0;
    chk_j("jrecover", 4'b0000, 0, 1'b0);
    check("jrecover err", 32'(j_err), 32'h1);
    check("jrecover ill", 32'(j_ill), 32'h0);
    j_clr = 1'b1;
    tick();
    j_clr = 1'b0;
    check("jclr err", 32'(j_err), 32'h0);

    // Recovery and clr_err on the same edge: err stays set
    j_load = 1'b1;
    tick();
    j_load = 1'b0; j_en = 1'b1; j_clr = 1'b1;
    tick();
    j_en = 1'b0; j_clr = 1'b0;
    check("jsetwins err", 32'(j_err), 32'h1);
    check("jsetwins q",   32'(j_q),   32'h0);
    j_clr = 1'b1;
    tick();
    j_clr = 1'b0;
    check("jclr2 err", 32'(j_err), 32'h0);

    // Load overrides en, and suppresses the wrap a step from 0001 would give
    j_lv = 4'b0001; j_load = 1'b1;
    tick();
    check("jload0001 idx", 32'(j_idx), 32'h7);
    j_lv = 4'b0011; j_en = 1'b1;
    tick();
    j_load = 1'b0; j_en = 1'b0;
    chk_j("jloaden", 4'b0011, 6, 1'b0);
    check("jloaden qbar", 32'(j_qbar), 32'hc);

    // Asynchronous reset between edges at q = 1110 with err set
    j_lv = 4'b0110; j_load = 1'b1;
    tick();
    j_load = 1'b0; j_en = 1'b1;
    tick();
    tick();
    tick();
    tick();
    j_en = 1'b0;
    chk_j("jpre_arst", 4'b1110, 3, 1'b0);
    check("jpre_arst err", 32'(j_err), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_j("jarst", 4'b0000, 0, 1'b0);
    check("jarst err", 32'(j_err), 32'h0);
    rst = 1'b0;
    j_en = 1'b1;
    tick();
    chk_j("jresume", 4'b1000, 1, 1'b0);

    // Reverse steps, wrap on 0 -> 7, and a direction flip with no dead cycle
    j_dir = 1'b1;
    tick();
    chk_j("jrev0", 4'b0000, 0, 1'b0);
    tick();
    chk_j("jrev1", 4'b0001, 7, 1'b1);
    j_dir = 1'b0;
    tick();
    chk_j("jflip", 4'b0000, 0, 1'b1);
    j_en = 1'b0;

    // Ring forward, then reverse
    r_en = 1'b1;
    tick();
    chk_r("rfwd0", 4'b0100, 1, 1'b0);
    tick();
    chk_r("rfwd1", 4'b0010, 2, 1'b0);
    tick();
    chk_r("rfwd2", 4'b0001, 3, 1'b0);
    tick();
    chk_r("rfwd3", 4'b1000, 0, 1'b1);
    r_dir = 1'b1;
    tick();
    chk_r("rrev0", 4'b0001, 3, 1'b1);
    tick();
    chk_r("rrev1", 4'b0010, 2, 1'b0);
    r_en = 1'b0;
    tick();
    chk_r("rhold", 4'b0010, 2, 1'b0);

    // Ring illegal code and recovery
    r_lv = 4'b0000; r_load = 1'b1;
    tick();
    r_load = 1'b0;
    check("rill ill", 32'(r_ill), 32'h1);
    check("rill idx", 32'(r_idx), 32'h0);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk_r("rrecover", 4'b1000, 0, 1'b0);
    check("rrecover err", 32'(r_err), 32'h1);
    check("rrecover ill", 32'(r_ill), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
